ysyx_22040088_lsu_ctrl: RTL and testbench
=========================================

Name: ysyx_22040088_lsu_ctrl

Overview:
Sequences every load/store of the single-issue RV64 core against a valid/ready data-memory port and stalls the core until the access completes. Performs address-alignment checks, store byte-lane steering, and load byte-lane right-alignment. Drives the one-hot size mask and the writeback source select consumed by the register-file write-data mux. Sits between decode/execute and the data-memory bus.

Parameters:
TIMEOUT, 255, max cycles in WAIT_RSP before an access fault; 0 disables the timeout
ADDR_W, 64, address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  instruction in EX is valid this cycle
is_load  in  1  EX instruction is a load
is_store  in  1  EX instruction is a store
funct3  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] = unsigned load
addr  in  ADDR_W  effective address from ALU
st_data  in  64  store data, LSB-aligned
dm_req_valid  out  1  memory request valid
dm_req_ready  in  1  memory accepts request
dm_req_we  out  1  1 = store
dm_req_addr  out  ADDR_W  address with [2:0] cleared
dm_req_wdata  out  64  st_data shifted left by 8*addr[2:0]
dm_req_wstrb  out  8  byte strobes, shifted by addr[2:0]
dm_rsp_valid  in  1  response valid; always accepted
dm_rsp_rdata  in  64  raw doubleword
dm_rsp_err  in  1  bus error
mem_rdata  out  64  dm_rsp_rdata shifted right by 8*addr[2:0], registered
mem_mask  out  4  one-hot: [0] D, [1] W, [2] H, [3] B
sel_rfwdata  out  3  one-hot: [0] ALU, [1] mem sign-extended, [2] mem zero-extended
rf_wen_mem  out  1  one-cycle pulse: load data valid for writeback
stall  out  1  hold PC/EX
fault  out  1  one-cycle pulse: misaligned, bus error, or timeout
fault_cause  out  2  01 misaligned, 10 bus error, 11 timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except sel_rfwdata=3'b001. Counter, captured address, size, and sign cleared.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, with ex_valid & (is_load|is_store):
  - Capture addr, funct3, st_data.
  - If misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0): fault=1 and cause=01 same cycle, no bus request, stay IDLE, stall=0.
  - Otherwise go to REQ; stall asserts combinationally that cycle.
- is_load & is_store both 1: treated as a load.
- REQ: dm_req_valid=1; address, data, and strobes stable until handshake. On dm_req_valid & dm_req_ready → WAIT_RSP, counter=0.
- WAIT_RSP: counter increments each cycle.
  - dm_rsp_valid & !dm_rsp_err → DONE; mem_rdata registered (loads).
  - dm_rsp_valid & dm_rsp_err → fault, cause=10, → IDLE.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without response → fault, cause=11, → IDLE.
  - Response in the same cycle as the timeout: the response wins.
- DONE (one cycle): rf_wen_mem=1 for loads only; stall=0; → IDLE.
  - A new access may be accepted in the following IDLE cycle.
  - Minimum load latency with zero-wait memory: 3 stall cycles.
- stall=1 in REQ and WAIT_RSP, and in the IDLE cycle that launches a legal access. Deasserts in DONE and on the fault cycle.
- mem_mask and sel_rfwdata are held from capture until the next capture.
  - Loads: sel_rfwdata = funct3[2] ? 100 : 010; mem_mask from size.
  - Stores, and idle after reset: sel_rfwdata = 001.
- wstrb base patterns: B 0x01, H 0x03, W 0x0F, D 0xFF, shifted left by addr[2:0].
- Stores ignore dm_rsp_rdata; the response only completes the transaction.
- Responses arriving in IDLE/REQ/DONE are ignored.
- Reset mid-transaction: immediate return to IDLE. An outstanding response after reset is ignored.

Test Plan:
- LD at 0x8000_0010, ready=1, rsp 1 cycle later with 0x1122334455667788 → mem_mask=0001, sel=010, rf_wen_mem pulse in DONE, mem_rdata=0x1122334455667788, stall high exactly 3 cycles.
- LBU at 0x8000_0013, rdata 0x00000000AB000000 → mem_rdata[7:0]=0xAB, mem_mask=1000, sel=100.
- SH at 0x8000_0006, st_data 0xBEEF → wstrb=0xC0, wdata[63:48]=0xBEEF, addr=0x8000_0000, dm_req_we=1, no rf_wen_mem.
- LW at 0x8000_0002 → fault=1, cause=01 same cycle, dm_req_valid never asserts, stall=0.
- SD with dm_req_ready low 5 cycles → request signals stable all 5 cycles, handshake on the 6th.
- Load with no response and TIMEOUT=4 → fault cause=11 on the 4th WAIT_RSP cycle. Separate case: rsp_err=1 → cause=10. Separate case: rst_n low during WAIT_RSP → IDLE, outputs at reset values.

Source files
------------

// File: rtl/ysyx_22040088_lsu_ctrl_if.sv
// Data-memory port between the LSU controller and the memory system.
//   Request:  dm_req_valid/ready handshake with we, doubleword-aligned addr,
//             lane-steered wdata and byte strobes.
//   Response: dm_rsp_valid (always accepted), raw doubleword rdata, bus error.
// The master modport is the LSU side and the slave modport is the memory side.
interface ysyx_22040088_lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              dm_req_valid;
  logic              dm_req_ready;
  logic              dm_req_we;
  logic [ADDR_W-1:0] dm_req_addr;
  logic [63:0]       dm_req_wdata;
  logic [7:0]        dm_req_wstrb;
  logic              dm_rsp_valid;
  logic [63:0]       dm_rsp_rdata;
  logic              dm_rsp_err;

  modport master (
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err
  );

  modport slave (
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_wstrb,
    output dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err
  );
endinterface

// File: rtl/ysyx_22040088_lsu.sv
// Load/store sequencer for the single-issue RV64 core.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_valid/is_load/is_store/funct3/addr/st_data   EX-stage access request
//   dm                   data-memory port (master side)
//   mem_rdata            load data right-aligned to byte 0, registered
//   mem_mask             one-hot size: [0] D, [1] W, [2] H, [3] B
//   sel_rfwdata          one-hot writeback source: ALU / mem sext / mem zext
//   rf_wen_mem           one-cycle pulse when load data is ready for writeback
//   stall                hold PC/EX while an access is in flight
//   fault/fault_cause    one-cycle pulse: 01 misaligned, 10 bus error, 11 timeout
module ysyx_22040088_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic [2:0]              funct3,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [63:0]             st_data,
  ysyx_22040088_lsu_ctrl_if.master dm,
  output logic [63:0]             mem_rdata,
  output logic [3:0]              mem_mask,
  output logic [2:0]              sel_rfwdata,
  output logic                    rf_wen_mem,
  output logic                    stall,
  output logic                    fault,
  output logic [1:0]              fault_cause
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              is_ld_q, is_ld_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [2:0]        sel_q, sel_d;

  logic              start;
  logic              misaligned;
  logic              timeout_hit;
  logic [7:0]        strb_base;
  logic [5:0]        byte_shift;

  assign start       = ex_valid & (is_load | is_store);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign byte_shift  = {addr_q[2:0], 3'b000};

  assign mem_rdata   = rdata_q;
  assign mem_mask    = mask_q;
  assign sel_rfwdata = sel_q;

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      2'b11:   misaligned = |addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    strb_base = 8'h01;
    case (size_q)
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    is_ld_d         = is_ld_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    mask_d          = mask_q;
    sel_d           = sel_q;
    stall           = 1'b0;
    fault           = 1'b0;
    fault_cause     = '0;
    rf_wen_mem      = 1'b0;
    dm.dm_req_valid = 1'b0;
    dm.dm_req_we    = 1'b0;
    dm.dm_req_addr  = '0;
    dm.dm_req_wdata = '0;
    dm.dm_req_wstrb = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          size_d  = funct3[1:0];
          is_ld_d = is_load;
          wdata_d = st_data;
          // B=00 lands on bit 3, D=11 on bit 0
          mask_d  = 4'b1000 >> funct3[1:0];
          sel_d   = is_load ? (funct3[2] ? 3'b100 : 3'b010) : 3'b001;
          if (misaligned) begin
            fault       = 1'b1;
            fault_cause = 2'b01;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall           = 1'b1;
        dm.dm_req_valid = 1'b1;
        dm.dm_req_we    = ~is_ld_q;
        dm.dm_req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        dm.dm_req_wdata = wdata_q << byte_shift;
        dm.dm_req_wstrb = strb_base << addr_q[2:0];
        if (dm.dm_req_ready) begin
          state_d = WAIT_RSP;
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        cnt_d = cnt_q + 32'd1;
        // A response in the timeout cycle takes priority over the timeout.
        if (dm.dm_rsp_valid) begin
          if (dm.dm_rsp_err) begin
            stall       = 1'b0;
            fault       = 1'b1;
            fault_cause = 2'b10;
            state_d     = IDLE;
          end else begin
            state_d = DONE;
            if (is_ld_q) rdata_d = dm.dm_rsp_rdata >> byte_shift;
          end
        end else if (timeout_hit) begin
          stall       = 1'b0;
          fault       = 1'b1;
          fault_cause = 2'b11;
          state_d     = IDLE;
        end
      end
      DONE: begin
        rf_wen_mem = is_ld_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      is_ld_q <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      sel_q   <= 3'b001;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      is_ld_q <= is_ld_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040088_lsu_ctrl.sv
module tb_ysyx_22040088_lsu_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] st_data = '0;
  logic [63:0] mem_rdata;
  logic [3:0]  mem_mask;
  logic [2:0]  sel_rfwdata;
  logic        rf_wen_mem;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  // Reference state: what the writeback-side outputs should currently hold.
  logic [63:0] exp_rdata = '0;
  logic [3:0]  exp_mask  = '0;
  logic [2:0]  exp_sel   = 3'b001;

  ysyx_22040088_lsu_ctrl_if #(.ADDR_W(64)) dm_if ();

  ysyx_22040088_lsu_ctrl #(.TIMEOUT(TO), .ADDR_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .is_load     (is_load),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .st_data     (st_data),
    .dm          (dm_if),
    .mem_rdata   (mem_rdata),
    .mem_mask    (mem_mask),
    .sel_rfwdata (sel_rfwdata),
    .rf_wen_mem  (rf_wen_mem),
    .stall       (stall),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte k of v moves to byte k+off; bytes pushed past lane 7 are dropped.
  function automatic logic [63:0] place_bytes(input logic [63:0] v, input int unsigned off);
    logic [63:0] r;
    r = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (k + off < 8) r[8*(k+off) +: 8] = v[8*k +: 8];
    return r;
  endfunction

  // Byte k+off of v moves down to byte k.
  function automatic logic [63:0] take_bytes(input logic [63:0] v, input int unsigned off);
    logic [63:0] r;
    r = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (k + off < 8) r[8*k +: 8] = v[8*(k+off) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_stall"}, 64'(stall), 64'd0);
    check({pfx, "_fault"}, 64'(fault), 64'd0);
    check({pfx, "_cause"}, 64'(fault_cause), 64'd0);
    check({pfx, "_rfwen"}, 64'(rf_wen_mem), 64'd0);
    check({pfx, "_mask"}, 64'(mem_mask), 64'd0);
    check({pfx, "_sel"}, 64'(sel_rfwdata), 64'd1);
    check({pfx, "_rdata"}, mem_rdata, 64'd0);
    check({pfx, "_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
    check({pfx, "_we"}, 64'(dm_if.dm_req_we), 64'd0);
    check({pfx, "_strb"}, 64'(dm_if.dm_req_wstrb), 64'd0);
  endtask

  // Drives one complete access from IDLE and checks every cycle against the
  // model. rsp_wait is the WAIT_RSP cycle index carrying the response; values
  // >= TO never respond and must time out.
  task automatic run_access(input string nm, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] sd, input int unsigned rdy_wait,
                            input int unsigned rsp_wait, input logic [63:0] rd,
                            input logic err);
    int unsigned sz, off, last, stalls, exp_stalls;
    logic        mis, timed_out, ok;
    logic [63:0] e_wdata;
    logic [7:0]  e_strb;

    sz      = int'(f3[1:0]);
    off     = int'(a[2:0]);
    mis     = (off % (1 << sz)) != 0;
    e_wdata = place_bytes(sd, off);
    e_strb  = '0;
    for (int unsigned k = 0; k < (1 << sz); k++)
      if (off + k < 8) e_strb[off+k] = 1'b1;

    ex_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; st_data = sd;
    dm_if.dm_req_ready = 1'b0;
    dm_if.dm_rsp_valid = 1'($urandom_range(0, 1));
    dm_if.dm_rsp_err   = 1'($urandom_range(0, 1));
    dm_if.dm_rsp_rdata = {$urandom(), $urandom()};
    @(negedge clk);
    check({nm, "_launch_fault"}, 64'(fault), 64'(mis));
    check({nm, "_launch_stall"}, 64'(stall), 64'(!mis));
    check({nm, "_launch_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
    if (mis) check({nm, "_mis_cause"}, 64'(fault_cause), 64'd1);
    stalls = stall ? 1 : 0;
    tick();

    ex_valid = 1'b0; addr = {$urandom(), $urandom()}; funct3 = 3'($urandom_range(0, 7));
    st_data = {$urandom(), $urandom()};
    exp_mask = 4'(8 >> sz);
    exp_sel  = ld ? (f3[2] ? 3'd4 : 3'd2) : 3'd1;

    if (mis) begin
      @(negedge clk);
      check({nm, "_mis_after_stall"}, 64'(stall), 64'd0);
      check({nm, "_mis_after_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
      check({nm, "_mis_after_fault"}, 64'(fault), 64'd0);
      check({nm, "_mis_mask"}, 64'(mem_mask), 64'(exp_mask));
      check({nm, "_mis_sel"}, 64'(sel_rfwdata), 64'(exp_sel));
      tick();
      return;
    end

    for (int unsigned i = 0; i <= rdy_wait; i++) begin
      dm_if.dm_req_ready = (i == rdy_wait);
      dm_if.dm_rsp_valid = 1'($urandom_range(0, 1));
      dm_if.dm_rsp_err   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({nm, "_req_valid"}, 64'(dm_if.dm_req_valid), 64'd1);
      check({nm, "_req_we"}, 64'(dm_if.dm_req_we), 64'(!ld));
      check({nm, "_req_addr"}, dm_if.dm_req_addr, a & ~64'h7);
      check({nm, "_req_wdata"}, dm_if.dm_req_wdata, e_wdata);
      check({nm, "_req_wstrb"}, 64'(dm_if.dm_req_wstrb), 64'(e_strb));
      check({nm, "_req_stall"}, 64'(stall), 64'd1);
      check({nm, "_req_fault"}, 64'(fault), 64'd0);
      check({nm, "_req_mask"}, 64'(mem_mask), 64'(exp_mask));
      check({nm, "_req_sel"}, 64'(sel_rfwdata), 64'(exp_sel));
      stalls += stall ? 1 : 0;
      tick();
    end

    dm_if.dm_req_ready = 1'b0;
    timed_out = (rsp_wait >= TO);
    last      = timed_out ? TO - 1 : rsp_wait;
    ok        = !timed_out && !err;
    for (int unsigned j = 0; j <= last; j++) begin
      dm_if.dm_rsp_valid = (j == rsp_wait);
      dm_if.dm_rsp_err   = err;
      dm_if.dm_rsp_rdata = rd;
      @(negedge clk);
      check({nm, "_wait_rfwen"}, 64'(rf_wen_mem), 64'd0);
      check({nm, "_wait_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
      if (j < last) begin
        check({nm, "_wait_stall"}, 64'(stall), 64'd1);
        check({nm, "_wait_fault"}, 64'(fault), 64'd0);
      end else if (timed_out) begin
        check({nm, "_timeout_fault"}, 64'(fault), 64'd1);
        check({nm, "_timeout_cause"}, 64'(fault_cause), 64'd3);
        check({nm, "_timeout_stall"}, 64'(stall), 64'd0);
      end else if (err) begin
        check({nm, "_buserr_fault"}, 64'(fault), 64'd1);
        check({nm, "_buserr_cause"}, 64'(fault_cause), 64'd2);
        check({nm, "_buserr_stall"}, 64'(stall), 64'd0);
      end else begin
        check({nm, "_rsp_fault"}, 64'(fault), 64'd0);
        check({nm, "_rsp_stall"}, 64'(stall), 64'd1);
      end
      stalls += stall ? 1 : 0;
      tick();
    end

    // Stray responses in DONE / IDLE must be ignored.
    dm_if.dm_rsp_valid = 1'($urandom_range(0, 1));
    dm_if.dm_rsp_err   = 1'($urandom_range(0, 1));
    dm_if.dm_rsp_rdata = {$urandom(), $urandom()};
    if (ok) begin
      if (ld) exp_rdata = take_bytes(rd, off);
      @(negedge clk);
      check({nm, "_done_rfwen"}, 64'(rf_wen_mem), 64'(ld));
      check({nm, "_done_stall"}, 64'(stall), 64'd0);
      check({nm, "_done_fault"}, 64'(fault), 64'd0);
      check({nm, "_done_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
      check({nm, "_done_rdata"}, mem_rdata, exp_rdata);
      tick();
    end

    exp_stalls = 1 + (rdy_wait + 1) + (ok ? last + 1 : last);
    check({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));

    @(negedge clk);
    check({nm, "_idle_stall"}, 64'(stall), 64'd0);
    check({nm, "_idle_rfwen"}, 64'(rf_wen_mem), 64'd0);
    check({nm, "_idle_reqv"}, 64'(dm_if.dm_req_valid), 64'd0);
    check({nm, "_idle_rdata"}, mem_rdata, exp_rdata);
    check({nm, "_idle_mask"}, 64'(mem_mask), 64'(exp_mask));
    check({nm, "_idle_sel"}, 64'(sel_rfwdata), 64'(exp_sel));
    tick();
    dm_if.dm_rsp_valid = 1'b0;
    dm_if.dm_rsp_err   = 1'b0;
  endtask

  initial begin
    int unsigned rf3, rrdy, rrsp;
    logic        rld, rst_bit, rerr;
    logic [63:0] ra;

    dm_if.dm_req_ready = 1'b0;
    dm_if.dm_rsp_valid = 1'b0;
    dm_if.dm_rsp_err   = 1'b0;
    dm_if.dm_rsp_rdata = '0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Directed cases
    run_access("ld_aligned", 1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'h0, 0, 0,
               64'h1122_3344_5566_7788, 1'b0);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 64'h8000_0013, 64'h0, 0, 0,
               64'h0000_0000_AB00_0000, 1'b0);
    check("lbu_byte", 64'(mem_rdata[7:0]), 64'hAB);
    run_access("sh", 1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hBEEF, 0, 0,
               64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
    run_access("lw_mis", 1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0, 0, 0, 64'h0, 1'b0);
    run_access("sd_backpressure", 1'b0, 1'b1, 3'b011, 64'h8000_0028,
               64'h0123_4567_89AB_CDEF, 5, 1, 64'h0, 1'b0);
    run_access("ld_timeout", 1'b1, 1'b0, 3'b011, 64'h8000_0030, 64'h0, 0, 10, 64'h0, 1'b0);
    run_access("ld_buserr", 1'b1, 1'b0, 3'b000, 64'h8000_0031, 64'h0, 1, 1, 64'h55, 1'b1);
    run_access("ld_tie", 1'b1, 1'b0, 3'b010, 64'h8000_0034, 64'h0, 0, TO - 1,
               64'hCAFE_F00D_1234_5678, 1'b0);
    run_access("ld_and_st", 1'b1, 1'b1, 3'b101, 64'h8000_0002, 64'hFFFF, 0, 0,
               64'h0000_0000_9876_0000, 1'b0);

    // ex_valid with neither load nor store launches nothing
    ex_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b010; addr = 64'h3;
    @(negedge clk);
    check("nop_stall", 64'(stall), 64'd0);
    check("nop_fault", 64'(fault), 64'd0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    check("nop_reqv", 64'(dm_if.dm_req_valid), 64'd0);
    check("nop_mask", 64'(mem_mask), 64'(exp_mask));
    tick();

    // Reset in the middle of WAIT_RSP, then a stale response
    ex_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h8000_0040;
    tick();
    ex_valid = 1'b0; dm_if.dm_req_ready = 1'b1;
    tick();
    dm_if.dm_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    exp_mask = '0; exp_sel = 3'b001; exp_rdata = '0;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    dm_if.dm_rsp_valid = 1'b1; dm_if.dm_rsp_err = 1'b0;
    dm_if.dm_rsp_rdata = 64'hFEED_FACE_0BAD_BEEF;
    @(negedge clk);
    check("stale_stall", 64'(stall), 64'd0);
    check("stale_fault", 64'(fault), 64'd0);
    tick();
    dm_if.dm_rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_rfwen", 64'(rf_wen_mem), 64'd0);
    check("stale_rdata", mem_rdata, 64'd0);
    tick();

    // Randomized accesses
    for (int unsigned n = 0; n < 40; n++) begin
      rf3     = $urandom_range(0, 7);
      ra      = {32'h8000_0000, $urandom()};
      if ($urandom_range(0, 3) != 0) ra = ra & ~((64'd1 << rf3[1:0]) - 64'd1);
      rld     = 1'($urandom_range(0, 1));
      rst_bit = !rld || ($urandom_range(0, 3) == 0);
      rrdy    = $urandom_range(0, 3);
      rrsp    = $urandom_range(0, 6);
      rerr    = ($urandom_range(0, 7) == 0);
      run_access("rand", rld, rst_bit, 3'(rf3), ra, {$urandom(), $urandom()}, rrdy, rrsp,
                 {$urandom(), $urandom()}, rerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
